control_unit_downsample: RTL and testbench

- 2x downsampler: reads an N x N feature map from the input BRAM once, in raster order.
- Reduces each 2x2 window to one pixel (rounded average) and writes an (N/2) x (N/2) map to the output BRAM in raster order.
- Inverse of the upsample controller; sits in the same feature-map buffer path, between the conv output buffer and the next stage's input buffer.
- Includes its own datapath: a horizontal pair adder, a line buffer and the 2x2 reducer.

---
 rtl/downsample_pkg.sv | 33 +++
 rtl/control_unit_downsample_if.sv | 22 ++
 rtl/line_buffer_downsample.sv | 25 ++
 rtl/control_unit_downsample.sv | 160 ++++++++++++++++
 tb/tb_control_unit_downsample.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/downsample_pkg.sv
// Shared constants for the 2x downsampler: FSM encoding, size codes, datapath growth.
// size_to_dim() maps a size code to the input edge length N, or 0 for an unsupported code.
package downsample_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] SIZE_8   = 3'd0;
  localparam logic [2:0] SIZE_16  = 3'd1;
  localparam logic [2:0] SIZE_32  = 3'd2;
  localparam logic [2:0] SIZE_64  = 3'd3;
  localparam logic [2:0] SIZE_128 = 3'd4;

  // Extra bits over DATA_W: a pair sum needs one, a four-pixel sum needs two.
  localparam int PAIR_EXT = 1;
  localparam int SUM_EXT  = 2;

  function automatic logic [7:0] size_to_dim(input logic [2:0] code);
    logic [7:0] dim;
    case (code)
      SIZE_8:   dim = 8'd8;
      SIZE_16:  dim = 8'd16;
      SIZE_32:  dim = 8'd32;
      SIZE_64:  dim = 8'd64;
      SIZE_128: dim = 8'd128;
      default:  dim = 8'd0;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/control_unit_downsample_if.sv
// Feature-map BRAM port bundle: input-buffer read side and output-buffer write side.
// master = downsampler, slave = memory/environment; no back-pressure on either side.
interface control_unit_downsample_if #(
  parameter int DATA_W = 16
);
  logic              en_read_in;
  logic [13:0]       addr_input;
  logic [DATA_W-1:0] data_in;
  logic              en_write_out;
  logic [13:0]       addr_output;
  logic [DATA_W-1:0] data_out;

  modport master (
    output en_read_in, addr_input, en_write_out, addr_output, data_out,
    input  data_in
  );

  modport slave (
    input  en_read_in, addr_input, en_write_out, addr_output, data_out,
    output data_in
  );
endinterface

// File: rtl/line_buffer_downsample.sv
// Simple dual-port row buffer holding one row of horizontal pair results.
// One write and one synchronous read per cycle; read data valid the cycle after rd_en_i.
module line_buffer_downsample #(
  parameter int W     = 17,
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_dat_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
    if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/control_unit_downsample.sv
// 2x downsampler: streams an N x N map from the input BRAM, writes (N/2)^2 rounded 2x2 averages
// (or signed 2x2 max when DOWNSAMPLE_MAXPOOL_EN is defined); done at N*N+2+RD_LAT, no back-pressure.
module control_unit_downsample
  import downsample_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_OUT_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               size_downsample,
  output logic                     busy,
  output logic                     done,
  control_unit_downsample_if.master bus
);
  localparam int LB_AW = (MAX_OUT_W > 1) ? $clog2(MAX_OUT_W) : 1;
  localparam int CNT_W = LB_AW + 1;
`ifdef DOWNSAMPLE_MAXPOOL_EN
  localparam int LB_W = DATA_W;
`else
  localparam int LB_W  = DATA_W + PAIR_EXT;
  localparam int SUM_W = DATA_W + SUM_EXT;
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(2);
`endif

  logic [1:0]        state_q, state_d;
  logic [7:0]        dim_q;
  logic [13:0]       last_q;
  logic              rd_en_q;
  logic [13:0]       rd_addr_q;
  logic [1:0]        flush_q;
  logic [RD_LAT-1:0] vld_q;
  logic [CNT_W-1:0]  col_q, row_q;
  logic [DATA_W-1:0] pix_q;
  logic              wr_en_q;
  logic [13:0]       wr_addr_q, wr_idx_q;
  logic [DATA_W-1:0] wr_dat_q;

  logic [7:0]        dim_in;
  logic [15:0]       dim_sq;
  logic              pix_vld, emit;
  logic [CNT_W-1:0]  col_last;
  logic [LB_W-1:0]   pair, lb_rd;
  logic [DATA_W-1:0] red;

  assign dim_in   = size_to_dim(size_downsample);
  assign dim_sq   = 16'(dim_in) * 16'(dim_in);
  assign pix_vld  = vld_q[RD_LAT-1];
  assign col_last = CNT_W'(dim_q - 8'd1);
  assign emit     = pix_vld & col_q[0] & row_q[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      // An unsupported size takes a single FLUSH cycle so done still lands two cycles after start.
      ST_IDLE:  if (start) state_d = (dim_in != 8'd0) ? ST_RUN : ST_FLUSH;
      ST_RUN:   if (rd_addr_q == last_q) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_q == 2'd0) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef DOWNSAMPLE_MAXPOOL_EN
  always_comb begin
    pair = ($signed(pix_q) > $signed(bus.data_in)) ? pix_q : bus.data_in;
    red  = ($signed(pair) > $signed(lb_rd)) ? pair : lb_rd;
  end
`else
  logic signed [SUM_W-1:0] sum_w;
  always_comb begin
    pair  = {pix_q[DATA_W-1], pix_q} + {bus.data_in[DATA_W-1], bus.data_in};
    sum_w = $signed({pair[LB_W-1], pair}) + $signed({lb_rd[LB_W-1], lb_rd});
    red   = DATA_W'((sum_w + RND) >>> 2);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dim_q     <= '0;
      last_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      flush_q   <= '0;
      vld_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pix_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_idx_q  <= '0;
      wr_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= (state_d == ST_RUN);
      vld_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];

      case (state_q)
        ST_IDLE: if (start) begin
          dim_q     <= dim_in;
          last_q    <= 14'(dim_sq - 16'd1);
          rd_addr_q <= '0;
          col_q     <= '0;
          row_q     <= '0;
          wr_idx_q  <= '0;
          flush_q   <= 2'd0;
        end
        ST_RUN: begin
          if (state_d == ST_RUN) rd_addr_q <= rd_addr_q + 14'd1;
          else flush_q <= 2'(RD_LAT);
        end
        ST_FLUSH: if (flush_q != 2'd0) flush_q <= flush_q - 2'd1;
        default: ;
      endcase

      // Counters follow the pixel on data_in, not the address being issued.
      if (pix_vld) begin
        if (col_q == col_last) begin
          col_q <= '0;
          row_q <= row_q + CNT_W'(1);
        end else begin
          col_q <= col_q + CNT_W'(1);
        end
        if (!col_q[0]) pix_q <= bus.data_in;
      end

      wr_en_q <= emit;
      if (emit) begin
        wr_addr_q <= wr_idx_q;
        wr_dat_q  <= red;
        wr_idx_q  <= wr_idx_q + 14'd1;
      end
    end
  end

  line_buffer_downsample #(
    .W     (LB_W),
    .DEPTH (MAX_OUT_W),
    .AW    (LB_AW)
  ) u_lb (
    .clk       (clk),
    .wr_en_i   (pix_vld & col_q[0] & ~row_q[0]),
    .wr_addr_i (col_q[CNT_W-1:1]),
    .wr_dat_i  (pair),
    .rd_en_i   (pix_vld & ~col_q[0] & row_q[0]),
    .rd_addr_i (col_q[CNT_W-1:1]),
    .rd_dat_o  (lb_rd)
  );

  assign bus.en_read_in   = rd_en_q;
  assign bus.addr_input   = rd_addr_q;
  assign bus.en_write_out = wr_en_q;
  assign bus.addr_output  = wr_addr_q;
  assign bus.data_out     = wr_dat_q;
  assign busy = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done = (state_q == ST_DONE);
endmodule

// File: tb/tb_control_unit_downsample.sv
// Bench for control_unit_downsample: BRAM model, reference model filling a scoreboard queue,
// and a negedge monitor that checks every write, every read address and the done pulse.
module tb_control_unit_downsample;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 1;
  localparam int MAX_OUT_W = 64;

  typedef struct {
    int addr;
    int dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] size_downsample = 3'd0;
  logic       busy, done;

  control_unit_downsample_if #(.DATA_W(DATA_W)) bus ();

  control_unit_downsample #(
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .MAX_OUT_W (MAX_OUT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .size_downsample (size_downsample),
    .busy            (busy),
    .done            (done),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Input BRAM model with RD_LAT cycles of read latency.
  logic signed [DATA_W-1:0] img [16384];
  logic signed [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= img[bus.addr_input];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.data_in = rd_pipe[RD_LAT-1];

  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  int t0 = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_at = -1;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.en_write_out) begin
        wr_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL write_unexpected: addr %0d data %0d, no write expected", bus.addr_output, $signed(bus.data_out));
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(bus.addr_output) != mon_e.addr || int'($signed(bus.data_out)) != mon_e.dat) begin
            fails++;
            $display("FAIL write: got addr %0d data %0d, expected addr %0d data %0d",
                     bus.addr_output, $signed(bus.data_out), mon_e.addr, mon_e.dat);
          end
        end
      end
      if (bus.en_read_in) begin
        if (rd_cnt == 0) chk("first_read_cycle", cyc - t0, 1);
        chk("read_addr", int'(bus.addr_input), rd_cnt);
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc - t0;
      end
    end
  end

  // Reference model: each output is the reduction of a 2x2 window, in raster order.
  task automatic build_expect(input int n);
    int a, b, c, d, v;
    exp_t e;
    for (int i = 0; i < n / 2; i++) begin
      for (int j = 0; j < n / 2; j++) begin
        a = int'(img[(2*i)*n + 2*j]);
        b = int'(img[(2*i)*n + 2*j + 1]);
        c = int'(img[(2*i+1)*n + 2*j]);
        d = int'(img[(2*i+1)*n + 2*j + 1]);
`ifdef DOWNSAMPLE_MAXPOOL_EN
        v = a;
        if (b > v) v = b;
        if (c > v) v = c;
        if (d > v) v = d;
`else
        v = (a + b + c + d + 2) >>> 2;
`endif
        e.addr = i * (n / 2) + j;
        e.dat  = v;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic kick(input int sz);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    size_downsample = 3'(sz);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    start = 1'b0;
    size_downsample = 3'($urandom_range(0, 7));
    if (sz <= 4) chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic finish_run(input int n, input int exp_done);
    int budget;
    budget = n * n + 64;
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    repeat (3) @(posedge clk);
    #2;
    chk("done_pulses", done_cnt, 1);
    chk("done_cycle", done_at, exp_done);
    chk("read_count", rd_cnt, n * n);
    chk("write_count", wr_cnt, (n / 2) * (n / 2));
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n * n; k++) img[k] = DATA_W'($urandom);
  endtask

  task automatic run_full(input int sz);
    int n;
    n = 8 << sz;
    build_expect(n);
    kick(sz);
    finish_run(n, n * n + 2 + RD_LAT);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_en_read_in"}, int'(bus.en_read_in), 0);
    chk({tag, "_addr_input"}, int'(bus.addr_input), 0);
    chk({tag, "_en_write_out"}, int'(bus.en_write_out), 0);
    chk({tag, "_addr_output"}, int'(bus.addr_output), 0);
    chk({tag, "_data_out"}, int'(bus.data_out), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 8x8 ramp: first output is (0+1+8+9+2)>>>2 = 5.
    for (int k = 0; k < 64; k++) img[k] = DATA_W'(k);
    run_full(0);

    // 8x8 random with hand-placed windows; stray start pulses mid-run must be ignored.
    fill_random(8);
    img[0] = 1;  img[1] = 2;  img[8] = 1;  img[9] = 1;
    img[2] = -1; img[3] = -1; img[10] = -1; img[11] = -2;
    img[4] = -7; img[5] = 3;  img[12] = 0; img[13] = -1;
    build_expect(8);
    kick(0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    size_downsample = 3'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run(8, 8 * 8 + 2 + RD_LAT);

    // 16x16 aborted by reset at cycle 20, then a clean 16x16 run.
    fill_random(16);
    build_expect(16);
    kick(1);
    while (cyc - t0 < 20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("abort");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_write", int'(bus.en_write_out), 0);
    fill_random(16);
    run_full(1);

    // Unsupported size codes: done two cycles after start, no memory traffic.
    kick(5);
    finish_run(0, 2);
    kick(7);
    finish_run(0, 2);

    fill_random(32);
    run_full(2);
    fill_random(64);
    run_full(3);

    // 128x128 constant -3: every output is (-12+2)>>>2 = -3.
    for (int k = 0; k < 16384; k++) img[k] = -3;
    run_full(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
